// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl_pkg
// Shared definitions for the NTT stage sequencer. It holds the default frame
// geometry for a 512-point transform on 32 lanes and the two-state
// sequencer FSM encoding.
// No ports: this is a package only.
package ntt_ctrl_pkg;

  localparam int NUM_STAGES_DEF   = 9;   // log2(512) butterfly stages
  localparam int FRAME_CYCLES_DEF = 16;  // 512 points / 32 lanes
  localparam int STAGE_LAT_DEF    = 8;   // start-to-start spacing of stages

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ntt_state_e;

endpackage

// File: rtl/stage_token_delay.sv
// stage_token_delay
// A fixed-depth shift register that carries a single-bit start token from
// one NTT stage to the next. clr empties the whole line in one cycle, so
// aborted frames leave no token behind.
// Ports:
//   clk   - clock, posedge
//   rst   - asynchronous active-high reset, empties the line
//   clr   - synchronous clear, empties the line on the next edge
//   tok_i - token entering the line
//   tok_o - token leaving the line, DEPTH cycles after it entered
module stage_token_delay #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tok_i,
  output logic tok_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // The shift-and-or form also works for DEPTH == 1, where a
  // part-select of the lower bits would be empty.
  always_comb begin
    sr_d = (sr_q << 1) | DEPTH'(tok_i);
    if (clr) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tok_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer
// Accepts frame requests, streams FRAME_CYCLES input beats per frame and
// fires one start pulse per NTT stage, each STAGE_LAT cycles after the one
// before. Several frames may be in flight at once; each one is a separate
// token moving down the stage delay chain.
// Ports:
//   clk         - clock, posedge
//   rst         - asynchronous active-high reset
//   req_valid   - a new frame is requested
//   req_ready   - a request is accepted this cycle if req_valid is high
//   flush       - abort every frame in flight
//   stage_start - per-stage one-cycle start pulses, index 0 = first stage
//   beat_valid  - an input beat is live this cycle
//   beat_idx    - lane-group index of the current beat
//   done        - one-cycle pulse when a frame leaves the last stage
//   in_flight   - number of accepted frames that are not yet done
//   busy        - streaming, or frames still in flight
module ntt_stage_sequencer
  import ntt_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = NUM_STAGES_DEF,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int STAGE_LAT    = STAGE_LAT_DEF
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              req_valid,
  output logic                                              req_ready,
  input  logic                                              flush,
  output logic                                              stage_start [NUM_STAGES-1:0],
  output logic                                              beat_valid,
  output logic [$clog2(FRAME_CYCLES)-1:0]                   beat_idx,
  output logic                                              done,
  output logic [$clog2(NUM_STAGES*STAGE_LAT/FRAME_CYCLES+2)-1:0] in_flight,
  output logic                                              busy
);

  localparam int BW = $clog2(FRAME_CYCLES);
  localparam int IW = $clog2(NUM_STAGES*STAGE_LAT/FRAME_CYCLES+2);

  ntt_state_e      state_q, state_d;
  logic [BW-1:0]   beat_idx_q, beat_idx_d;
  logic [IW-1:0]   in_flight_q, in_flight_d;
  logic            start_q;
  logic            accept;
  logic            last_beat;
  logic            tap [NUM_STAGES:0];

  assign last_beat = (state_q == STREAM) && (beat_idx_q == BW'(FRAME_CYCLES-1));

  // A new frame may start in IDLE or exactly on the last beat, which gives
  // gap-free back-to-back streaming. Flush always wins; while reset is held
  // nothing may be accepted either.
  assign req_ready = ((state_q == IDLE) || last_beat) && !flush && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    in_flight_d = in_flight_q;
    if (flush) begin
      state_d     = IDLE;
      beat_idx_d  = '0;
      in_flight_d = '0;
    end else begin
      if (accept) begin
        state_d    = STREAM;
        beat_idx_d = '0;
      end else if (state_q == STREAM) begin
        if (last_beat) begin
          state_d    = IDLE;
          beat_idx_d = '0;
        end else begin
          beat_idx_d = beat_idx_q + BW'(1);
        end
      end
      // An accept and a done in the same cycle cancel out.
      if (accept && !tap[NUM_STAGES]) begin
        in_flight_d = in_flight_q + IW'(1);
      end else if (!accept && tap[NUM_STAGES]) begin
        in_flight_d = in_flight_q - IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      in_flight_q <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      in_flight_q <= in_flight_d;
      start_q     <= accept;  // accept is already forced low by flush
    end
  end

  // Stage 0 fires the cycle after acceptance; each delay section then
  // hands the token to the next stage, and the last section's output is done.
  assign tap[0] = start_q;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      stage_token_delay #(
        .DEPTH (STAGE_LAT)
      ) u_dly (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .tok_i (tap[gi]),
        .tok_o (tap[gi+1])
      );
      assign stage_start[gi] = tap[gi];
    end
  endgenerate

  assign done       = tap[NUM_STAGES];
  assign beat_valid = (state_q == STREAM);
  assign beat_idx   = beat_idx_q;
  assign in_flight  = in_flight_q;
  assign busy       = (state_q != IDLE) || (in_flight_q != '0);

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb_ntt_stage_sequencer
// Directed and random stimulus for ntt_stage_sequencer. The reference model
// keeps only the list of accepted frame start cycles and derives every
// expected output from the timing rules of a frame.
module tb_ntt_stage_sequencer;
  import ntt_ctrl_pkg::*;

  localparam int N  = NUM_STAGES_DEF;
  localparam int FC = FRAME_CYCLES_DEF;
  localparam int L  = STAGE_LAT_DEF;
  localparam int BW = $clog2(FC);
  localparam int IW = $clog2(N*L/FC+2);

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          flush;
  logic          stage_start [N-1:0];
  logic          beat_valid;
  logic [BW-1:0] beat_idx;
  logic          done;
  logic [IW-1:0] in_flight;
  logic          busy;

  ntt_stage_sequencer #(
    .NUM_STAGES   (N),
    .FRAME_CYCLES (FC),
    .STAGE_LAT    (L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .flush       (flush),
    .stage_start (stage_start),
    .beat_valid  (beat_valid),
    .beat_idx    (beat_idx),
    .done        (done),
    .in_flight   (in_flight),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_q[$];   // cycles at which frames were accepted (not flushed)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_bv(input int c);
    foreach (acc_q[i]) if (c >= acc_q[i] + 1 && c <= acc_q[i] + FC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_idx(input int c);
    int r = 0;
    foreach (acc_q[i]) if (c >= acc_q[i] + 1 && c <= acc_q[i] + FC) r = c - acc_q[i] - 1;
    return r;
  endfunction

  function automatic logic [N-1:0] m_ss(input int c);
    logic [N-1:0] r = '0;
    for (int k = 0; k < N; k++)
      foreach (acc_q[i]) if (c == acc_q[i] + 1 + k*L) r[k] = 1'b1;
    return r;
  endfunction

  function automatic bit m_done(input int c);
    foreach (acc_q[i]) if (c == acc_q[i] + 1 + N*L) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_inflight(input int c);
    int r = 0;
    foreach (acc_q[i]) if (c >= acc_q[i] + 1 && c <= acc_q[i] + 1 + N*L) r++;
    return r;
  endfunction

  function automatic logic [N-1:0] obs_ss();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = stage_start[k];
    return r;
  endfunction

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model across the clock edge.
  task automatic cycle(input logic rv, input logic fl);
    bit bv;
    int idx;
    int inf;
    bit rdy;
    req_valid = rv;
    flush     = fl;
    #1;
    bv  = m_bv(cyc);
    idx = m_idx(cyc);
    inf = m_inflight(cyc);
    rdy = !fl && (!bv || idx == FC - 1);
    chk("req_ready",   32'(req_ready),  32'(rdy));
    chk("beat_valid",  32'(beat_valid), 32'(bv));
    chk("beat_idx",    32'(beat_idx),   32'(idx));
    chk("stage_start", 32'(obs_ss()),   32'(m_ss(cyc)));
    chk("done",        32'(done),       32'(m_done(cyc)));
    chk("in_flight",   32'(in_flight),  32'(inf));
    chk("busy",        32'(busy),       32'(bv || inf != 0));
    @(posedge clk);
    if (fl) acc_q.delete();
    else if (rv && rdy) acc_q.push_back(cyc);
    cyc++;
    while (acc_q.size() > 0 && acc_q[0] + N*L + 2 < cyc) void'(acc_q.pop_front());
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_beat_valid"},  32'(beat_valid), 32'd0);
    chk({tag, "_beat_idx"},    32'(beat_idx),   32'd0);
    chk({tag, "_stage_start"}, 32'(obs_ss()),   32'd0);
    chk({tag, "_done"},        32'(done),       32'd0);
    chk({tag, "_in_flight"},   32'(in_flight),  32'd0);
    chk({tag, "_busy"},        32'(busy),       32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    cyc = 0;

    // Single frame requested at cycle 10.
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (80) cycle(1'b0, 1'b0);

    // Back-to-back: req_valid held until three frames are accepted.
    repeat (33) cycle(1'b1, 1'b0);
    repeat (110) cycle(1'b0, 1'b0);

    // Request raised at beat 5, only taken on beat 15.
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    repeat (11) cycle(1'b1, 1'b0);
    repeat (100) cycle(1'b0, 1'b0);

    // Flush with two frames in flight, new request right after.
    cycle(1'b1, 1'b0);
    repeat (16) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    repeat (90) cycle(1'b0, 1'b0);

    // Flush together with a request: not accepted.
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    // Flush in the same cycle as done.
    cycle(1'b1, 1'b0);
    repeat (72) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    // Random traffic with occasional flushes.
    repeat (1500) cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    repeat (90) cycle(1'b0, 1'b0);

    // Asynchronous reset between clock edges in the middle of a frame.
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    acc_q.delete();
    @(posedge clk);
    cyc++;
    #1;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (80) cycle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
